// File: rtl/beinmotion_qsys_cpu_oci_pkg.sv
// Shared widths, atom codes and packer state encoding for the CPU OCI
// direct-compressed-trace path.
`default_nettype none

package beinmotion_qsys_cpu_oci_pkg;

  localparam int ATOM_W = 2;
  localparam int ATOMS  = 15;
  localparam int BUF_W  = ATOM_W * ATOMS;
  localparam int CNT_W  = 4;

  localparam logic [ATOM_W-1:0] ATOM_NULL = 2'b00;
  localparam logic [ATOM_W-1:0] ATOM_01   = 2'b01;
  localparam logic [ATOM_W-1:0] ATOM_10   = 2'b10;
  localparam logic [ATOM_W-1:0] ATOM_11   = 2'b11;

  typedef enum logic [1:0] {
    DCT_EMPTY = 2'd0,
    DCT_FILL  = 2'd1,
    DCT_FULL  = 2'd2
  } dct_state_e;

endpackage

`default_nettype wire

// File: rtl/beinmotion_qsys_cpu_oci_dct_frame_reg.sv
// Single-entry valid/ready holding register for one DCT frame.
`default_nettype none

module beinmotion_qsys_cpu_oci_dct_frame_reg
  import beinmotion_qsys_cpu_oci_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic [BUF_W-1:0] data_i,
  input  logic [CNT_W-1:0] count_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [BUF_W-1:0] data_o,
  output logic [CNT_W-1:0] count_o
);

  logic             valid_q;
  logic [BUF_W-1:0] data_q;
  logic [CNT_W-1:0] count_q;

  // A load in the accept cycle replaces the frame back-to-back; payload
  // changes only on load, so it stays stable while stalled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      count_q <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
      count_q <= count_i;
    end else if (valid_q && ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/beinmotion_qsys_cpu_oci_dct_packer.sv
// Packs 2-bit trace atoms into a 15-atom DCT buffer and hands completed or
// flushed buffers to the trace store through a one-entry frame register.
`default_nettype none

module beinmotion_qsys_cpu_oci_dct_packer
  import beinmotion_qsys_cpu_oci_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              trace_enable,
  input  logic              atom_valid,
  input  logic [ATOM_W-1:0] atom_code,
  input  logic              flush,
  output logic [BUF_W-1:0]  dct_buffer,
  output logic [CNT_W-1:0]  dct_count,
  output logic              frm_valid,
  output logic [BUF_W-1:0]  frm_data,
  output logic [CNT_W-1:0]  frm_count,
  input  logic              frm_ready,
  output logic              overflow,
  input  logic              overflow_clr
);

  dct_state_e       state_q, state_d;
  logic [BUF_W-1:0] buf_q, buf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pend_q, pend_d;
  logic             ovf_q, ovf_d;

  logic acc;
  logic slot_free;
  logic xfer;

  assign acc       = atom_valid & trace_enable & (atom_code != ATOM_NULL);
  assign slot_free = ~frm_valid | frm_ready;
  assign xfer      = slot_free & ((state_q == DCT_FULL) |
                                  (pend_q & (state_q != DCT_EMPTY)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= DCT_EMPTY;
      buf_q   <= '0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q & ~overflow_clr;
    if (xfer) begin
      if (acc) begin
        buf_d   = {{(BUF_W-ATOM_W){1'b0}}, atom_code};
        cnt_d   = CNT_W'(1);
        state_d = DCT_FILL;
      end else begin
        buf_d   = '0;
        cnt_d   = '0;
        state_d = DCT_EMPTY;
      end
    end else if (acc) begin
      if (state_q == DCT_FULL) begin
        ovf_d = 1'b1;
      end else begin
        buf_d   = {buf_q[BUF_W-ATOM_W-1:0], atom_code};
        cnt_d   = cnt_q + CNT_W'(1);
        state_d = (cnt_q == CNT_W'(ATOMS-1)) ? DCT_FULL : DCT_FILL;
      end
    end
    // A pending flush is meaningless once the buffer is empty, so it is
    // dropped rather than left waiting for a future atom.
    pend_d = (flush | (pend_q & ~xfer)) & (cnt_d != '0);
  end

  beinmotion_qsys_cpu_oci_dct_frame_reg u_frame_reg (
    .clk     (clk),
    .reset   (reset),
    .load_i  (xfer),
    .data_i  (buf_q),
    .count_i (cnt_q),
    .ready_i (frm_ready),
    .valid_o (frm_valid),
    .data_o  (frm_data),
    .count_o (frm_count)
  );

  assign dct_buffer = buf_q;
  assign dct_count  = cnt_q;
  assign overflow   = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_beinmotion_qsys_cpu_oci_dct_packer.sv
// Directed and randomized checks of the DCT packer against a queue-based model.
`default_nettype none

module tb_beinmotion_qsys_cpu_oci_dct_packer;

  logic        clk = 1'b0;
  logic        reset;
  logic        trace_enable;
  logic        atom_valid;
  logic [1:0]  atom_code;
  logic        flush;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        frm_valid;
  logic [29:0] frm_data;
  logic [3:0]  frm_count;
  logic        frm_ready;
  logic        overflow;
  logic        overflow_clr;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: the buffer is simply the list of stored atoms.
  logic [1:0]  mq[$];
  logic        m_fv, m_pend, m_ovf;
  logic [29:0] m_fd;
  logic [3:0]  m_fc;

  always #5 clk = ~clk;

  beinmotion_qsys_cpu_oci_dct_packer dut (
    .clk          (clk),
    .reset        (reset),
    .trace_enable (trace_enable),
    .atom_valid   (atom_valid),
    .atom_code    (atom_code),
    .flush        (flush),
    .dct_buffer   (dct_buffer),
    .dct_count    (dct_count),
    .frm_valid    (frm_valid),
    .frm_data     (frm_data),
    .frm_count    (frm_count),
    .frm_ready    (frm_ready),
    .overflow     (overflow),
    .overflow_clr (overflow_clr)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [29:0] m_pack();
    logic [29:0] b = '0;
    foreach (mq[i]) b = {b[27:0], mq[i]};
    return b;
  endfunction

  task automatic m_reset();
    mq.delete();
    m_fv = 0; m_pend = 0; m_ovf = 0; m_fd = '0; m_fc = '0;
  endtask

  task automatic m_step(input logic av, input logic en, input logic [1:0] code,
                        input logic fl, input logic rdy, input logic clr);
    logic acc, x, drop;
    acc  = av && en && (code != 2'b00);
    x    = (!m_fv || rdy) && (mq.size() == 15 || (m_pend && mq.size() != 0));
    drop = 0;
    if (x) begin
      m_fd = m_pack(); m_fc = 4'(mq.size()); m_fv = 1; mq.delete();
    end else if (m_fv && rdy) begin
      m_fv = 0;
    end
    if (acc) begin
      if (mq.size() < 15) mq.push_back(code);
      else drop = 1;
    end
    m_ovf  = drop ? 1'b1 : (clr ? 1'b0 : m_ovf);
    m_pend = (fl || (m_pend && !x)) && mq.size() != 0;
  endtask

  task automatic check_all();
    chk("dct_buffer", 32'(dct_buffer), 32'(m_pack()));
    chk("dct_count", 32'(dct_count), 32'(mq.size()));
    chk("frm_valid", 32'(frm_valid), 32'(m_fv));
    if (m_fv) begin
      chk("frm_data", 32'(frm_data), 32'(m_fd));
      chk("frm_count", 32'(frm_count), 32'(m_fc));
    end
    chk("overflow", 32'(overflow), 32'(m_ovf));
  endtask

  task automatic step(input logic av, input logic en, input logic [1:0] code,
                      input logic fl, input logic rdy, input logic clr);
    atom_valid = av; trace_enable = en; atom_code = code;
    flush = fl; frm_ready = rdy; overflow_clr = clr;
    @(posedge clk);
    m_step(av, en, code, fl, rdy, clr);
    #1;
    check_all();
  endtask

  task automatic idle(input logic rdy);
    step(0, 1, 2'b00, 0, rdy, 0);
  endtask

  initial begin
    reset = 1; trace_enable = 0; atom_valid = 0; atom_code = 0;
    flush = 0; frm_ready = 0; overflow_clr = 0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_buf", 32'(dct_buffer), 0);
    chk("rst_cnt", 32'(dct_count), 0);
    chk("rst_fv", 32'(frm_valid), 0);
    chk("rst_ovf", 32'(overflow), 0);
    reset = 0;

    // full frame
    for (int i = 0; i < 15; i++) step(1, 1, 2'b01, 0, 1, 0);
    chk("full_cnt15", 32'(dct_count), 15);
    idle(1);
    chk("full_fv", 32'(frm_valid), 1);
    chk("full_data", 32'(frm_data), 32'h15555555);
    chk("full_fc", 32'(frm_count), 15);
    chk("full_cnt0", 32'(dct_count), 0);

    // flush of a partial buffer, then flush of an empty one
    step(1, 1, 2'b01, 0, 1, 0);
    step(1, 1, 2'b10, 0, 1, 0);
    step(1, 1, 2'b11, 0, 1, 0);
    step(0, 1, 2'b00, 1, 1, 0);
    idle(1);
    chk("flush_fv", 32'(frm_valid), 1);
    chk("flush_data", 32'(frm_data), 32'h0000001B);
    chk("flush_fc", 32'(frm_count), 3);
    idle(1);
    step(0, 1, 2'b00, 1, 1, 0);
    idle(1);
    idle(1);
    chk("flush0_fv", 32'(frm_valid), 0);

    // back-pressure and overflow
    for (int i = 0; i < 31; i++) step(1, 1, 2'b10, 0, 0, 0);
    chk("bp_fv", 32'(frm_valid), 1);
    chk("bp_data", 32'(frm_data), 32'h2AAAAAAA);
    chk("bp_cnt", 32'(dct_count), 15);
    chk("bp_ovf", 32'(overflow), 1);
    idle(1);
    chk("bp2_fv", 32'(frm_valid), 1);
    chk("bp2_fc", 32'(frm_count), 15);
    chk("bp2_cnt", 32'(dct_count), 0);
    step(0, 1, 2'b00, 0, 1, 1);
    chk("ovf_clr", 32'(overflow), 0);

    // atom arriving in the transfer cycle
    for (int i = 0; i < 15; i++) step(1, 1, 2'b01, 0, 1, 0);
    step(1, 1, 2'b11, 0, 1, 0);
    chk("sim_fc", 32'(frm_count), 15);
    chk("sim_buf", 32'(dct_buffer), 3);
    chk("sim_cnt", 32'(dct_count), 1);

    // filtering
    step(1, 1, 2'b00, 0, 1, 0);
    step(1, 0, 2'b11, 0, 1, 0);
    chk("filt_cnt", 32'(dct_count), 1);
    step(0, 1, 2'b00, 1, 1, 0);
    idle(1);
    idle(1);

    // asynchronous reset mid-operation
    for (int i = 0; i < 22; i++) step(1, 1, 2'b11, 0, 0, 0);
    chk("pre_rst_cnt", 32'(dct_count), 7);
    chk("pre_rst_fv", 32'(frm_valid), 1);
    #2 reset = 1;
    #1;
    chk("arst_buf", 32'(dct_buffer), 0);
    chk("arst_cnt", 32'(dct_count), 0);
    chk("arst_fv", 32'(frm_valid), 0);
    chk("arst_fd", 32'(frm_data), 0);
    chk("arst_fc", 32'(frm_count), 0);
    m_reset();
    @(posedge clk);
    #1 reset = 0;
    for (int i = 0; i < 3; i++) idle(1);
    chk("post_rst_fv", 32'(frm_valid), 0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 4) != 0, ($urandom % 8) != 0, 2'($urandom),
           ($urandom % 16) == 0, ($urandom % 3) != 0, ($urandom % 32) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
